go_game_ctrl: RTL and testbench
===============================

// Module: go_game_ctrl
// PURPOSE
//  Parametrised Go game controller for an N x N board: accepts one move at a time, hands
//  placements to the external board updater, and commits the board and ko snapshot on success.
//  Alternates turn, pulses tx_ready when the local player's move must go to the peer, and
//  ends the game on two consecutive passes or a resign.
// PARAMETERS
//  BOARD_N      9     board edge length, 2..15; board vectors are 2*BOARD_N*BOARD_N bits
//  UPD_TIMEOUT  1023  max cycles to wait for an updater verdict before rejecting the move
//  CNT_W        9     width of move_count, saturating counter
// PORTS
//  clk_in         in   1          system clock
//  rst_in_n       in   1          asynchronous, active-low reset
//  move_avail     in   1          1-cycle strobe; move is valid this cycle
//  move           in   8          {row[7:4], col[3:0]}; 8'hFF = pass, 8'hFE = resign
//  my_color       in   1          local player colour (0 = black, 1 = white)
//  upd_start      out  1          1-cycle start strobe to the board updater
//  upd_move       out  8          latched move presented to the updater; stable while busy
//  upd_next_board in   2*N*N      updater result; sampled only when upd_valid is high
//  upd_valid      in   1          updater verdict: move is legal
//  upd_invalid    in   1          updater verdict: move is illegal
//  board_bus      out  2*N*N      committed board, 2 bits per point, row-major; 2'b00 = empty
//  ko_board       out  2*N*N      board before the last committed placement
//  turn           out  1          colour to move
//  tx_ready       out  1          1-cycle pulse: committed move was ours, send it to the peer
//  invalid_move   out  1          1-cycle pulse: move rejected
//  busy           out  1          high in any state other than IDLE
//  game_over      out  1          sticky until reset
//  resigned       out  1          sticky: game ended by resign
//  loser          out  1          colour that resigned; valid when resigned = 1
//  move_count     out  CNT_W      committed moves and passes; saturates at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - Every output is 0 and both boards are empty.
//   - turn = 0 (black moves first); state = IDLE.
//   - Reset during any state aborts the move in flight with no further pulses.
//  States: IDLE, WAIT_UPD, COMMIT, SEND, OVER.
//  IDLE, when move_avail is sampled high at edge k (move is latched into upd_move):
//   - Resign: from edge k, game_over = 1, resigned = 1, loser = turn; go to OVER.
//     No tx_ready pulse is generated.
//   - Pass: pass_cnt++; ko_board is cleared to empty; go to SEND.
//   - Placement with row >= BOARD_N or col >= BOARD_N: invalid_move high for edge k..k+1;
//     stay in IDLE.
//   - Legal-range placement: upd_start high for edge k..k+1; timer = 0; go to WAIT_UPD.
//  WAIT_UPD
//   - move_avail is ignored; the timer increments each cycle.
//   - upd_valid: go to COMMIT.
//   - upd_invalid, or timer == UPD_TIMEOUT: invalid_move pulses for 1 cycle; return to IDLE.
//   - upd_valid and upd_invalid in the same cycle: invalid wins.
//  COMMIT (one cycle, no verdict wait)
//   - ko_board <= board_bus; board_bus <= upd_next_board; pass_cnt <= 0; go to SEND.
//  SEND (one cycle)
//   - tx_ready <= (turn == my_color), high for exactly 1 cycle.
//   - turn <= ~turn; move_count++ with saturation.
//   - If pass_cnt == 2: game_over = 1 and go to OVER; otherwise go to IDLE.
//  OVER
//   - All inputs are ignored; busy stays 1; only reset exits.
//  Latency
//   - Placement: upd_valid sampled at edge j -> board_bus updated after edge j+1;
//     turn and tx_ready after edge j+2.
//   - Pass: move_avail at edge k -> turn and tx_ready after edge k+1.
//  Rules
//   - A new move is accepted only in IDLE; a strobe arriving in any other state is dropped
//     with no invalid_move pulse.
//   - pass_cnt is 2 bits and saturates at 2.
// TESTING
//  1. Reset, then move 8'h44 with upd_valid 3 cycles later -> board_bus = upd_next_board;
//     ko_board = empty; turn = 1; tx_ready pulses only if my_color = 0; move_count = 1.
//  2. BOARD_N = 9, move 8'h90 -> invalid_move 1-cycle pulse, no upd_start, turn unchanged.
//  3. Pass, then a pass by the other colour -> two SENDs, turn back to 0, game_over = 1;
//     a later move_avail is ignored.
//  4. Pass, placement, pass -> pass_cnt resets on the commit; game_over stays 0.
//  5. Updater never answers, UPD_TIMEOUT = 15 -> invalid_move 16 cycles after upd_start;
//     state returns to IDLE.
//  6. upd_valid and upd_invalid together -> invalid path; rst_in_n pulled low mid WAIT_UPD
//     -> all outputs 0 immediately.

Source files
------------

// File: rtl/go_game_ctrl_if.sv
// Signal bundle between the Go game controller and its environment
// (move source, peer link, external board updater).
interface go_game_ctrl_if #(
    parameter int BOARD_N = 9,
    parameter int CNT_W   = 9
);
    localparam int BW = 2 * BOARD_N * BOARD_N;

    logic             move_avail;
    logic [7:0]       move;
    logic             my_color;
    logic             upd_start;
    logic [7:0]       upd_move;
    logic [BW-1:0]    upd_next_board;
    logic             upd_valid;
    logic             upd_invalid;
    logic [BW-1:0]    board_bus;
    logic [BW-1:0]    ko_board;
    logic             turn;
    logic             tx_ready;
    logic             invalid_move;
    logic             busy;
    logic             game_over;
    logic             resigned;
    logic             loser;
    logic [CNT_W-1:0] move_count;

    // Environment side: supplies moves and updater verdicts
    modport master (
        output move_avail, move, my_color, upd_next_board, upd_valid, upd_invalid,
        input  upd_start, upd_move, board_bus, ko_board, turn, tx_ready,
        input  invalid_move, busy, game_over, resigned, loser, move_count
    );

    // Controller side
    modport slave (
        input  move_avail, move, my_color, upd_next_board, upd_valid, upd_invalid,
        output upd_start, upd_move, board_bus, ko_board, turn, tx_ready,
        output invalid_move, busy, game_over, resigned, loser, move_count
    );
endinterface

// File: rtl/go_game_ctrl.sv
// Go game controller: sequences one move at a time through the external board
// updater, commits board/ko snapshots, alternates turn and detects end of game.
module go_game_ctrl #(
    parameter int BOARD_N     = 9,
    parameter int UPD_TIMEOUT = 1023,
    parameter int CNT_W       = 9
) (
    input  logic          clk_in,
    input  logic          rst_in_n,
    go_game_ctrl_if.slave gif
);
    localparam int BW = 2 * BOARD_N * BOARD_N;
    localparam int TW = (UPD_TIMEOUT < 2) ? 1 : $clog2(UPD_TIMEOUT + 1);

    localparam logic [7:0]    MV_PASS   = 8'hFF;
    localparam logic [7:0]    MV_RESIGN = 8'hFE;
    localparam logic [3:0]    EDGE_N    = 4'(BOARD_N);
    localparam logic [TW-1:0] TMO       = TW'(UPD_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_UPD = 3'd1,
        S_COMMIT   = 3'd2,
        S_SEND     = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [7:0]       move_q,      move_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic [1:0]       pass_cnt_q,  pass_cnt_d;
    logic [BW-1:0]    next_brd_q,  next_brd_d;
    logic [BW-1:0]    board_q,     board_d;
    logic [BW-1:0]    ko_q,        ko_d;
    logic             turn_q,      turn_d;
    logic             upd_start_q, upd_start_d;
    logic             tx_ready_q,  tx_ready_d;
    logic             invalid_q,   invalid_d;
    logic             busy_q,      busy_d;
    logic             over_q,      over_d;
    logic             resigned_q,  resigned_d;
    logic             loser_q,     loser_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic in_range_s;
    assign in_range_s = (gif.move[7:4] < EDGE_N) && (gif.move[3:0] < EDGE_N);

    // Next-state and output computation for the move sequencer
    always_comb begin
        state_d     = state_q;
        move_d      = move_q;
        timer_d     = timer_q;
        pass_cnt_d  = pass_cnt_q;
        next_brd_d  = next_brd_q;
        board_d     = board_q;
        ko_d        = ko_q;
        turn_d      = turn_q;
        upd_start_d = 1'b0;
        tx_ready_d  = 1'b0;
        invalid_d   = 1'b0;
        over_d      = over_q;
        resigned_d  = resigned_q;
        loser_d     = loser_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (gif.move_avail) begin
                    move_d = gif.move;
                    if (gif.move == MV_RESIGN) begin
                        over_d     = 1'b1;
                        resigned_d = 1'b1;
                        loser_d    = turn_q;
                        state_d    = S_OVER;
                    end else if (gif.move == MV_PASS) begin
                        pass_cnt_d = (pass_cnt_q == 2'd2) ? 2'd2 : pass_cnt_q + 2'd1;
                        ko_d       = '0;
                        state_d    = S_SEND;
                    end else if (!in_range_s) begin
                        invalid_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        upd_start_d = 1'b1;
                        timer_d     = '0;
                        state_d     = S_WAIT_UPD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            // A rejection (explicit or by timeout) takes priority over a valid verdict
            S_WAIT_UPD: begin
                if (gif.upd_invalid || (timer_q == TMO)) begin
                    invalid_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (gif.upd_valid) begin
                    next_brd_d = gif.upd_next_board;
                    state_d    = S_COMMIT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_COMMIT: begin
                ko_d       = board_q;
                board_d    = next_brd_q;
                pass_cnt_d = 2'd0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_ready_d = (turn_q == gif.my_color);
                turn_d     = ~turn_q;
                count_d    = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                if (pass_cnt_q == 2'd2) begin
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= S_IDLE;
            move_q      <= 8'h00;
            timer_q     <= '0;
            pass_cnt_q  <= 2'd0;
            next_brd_q  <= '0;
            board_q     <= '0;
            ko_q        <= '0;
            turn_q      <= 1'b0;
            upd_start_q <= 1'b0;
            tx_ready_q  <= 1'b0;
            invalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            over_q      <= 1'b0;
            resigned_q  <= 1'b0;
            loser_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            move_q      <= move_d;
            timer_q     <= timer_d;
            pass_cnt_q  <= pass_cnt_d;
            next_brd_q  <= next_brd_d;
            board_q     <= board_d;
            ko_q        <= ko_d;
            turn_q      <= turn_d;
            upd_start_q <= upd_start_d;
            tx_ready_q  <= tx_ready_d;
            invalid_q   <= invalid_d;
            busy_q      <= busy_d;
            over_q      <= over_d;
            resigned_q  <= resigned_d;
            loser_q     <= loser_d;
            count_q     <= count_d;
        end
    end

    assign gif.upd_start    = upd_start_q;
    assign gif.upd_move     = move_q;
    assign gif.board_bus    = board_q;
    assign gif.ko_board     = ko_q;
    assign gif.turn         = turn_q;
    assign gif.tx_ready     = tx_ready_q;
    assign gif.invalid_move = invalid_q;
    assign gif.busy         = busy_q;
    assign gif.game_over    = over_q;
    assign gif.resigned     = resigned_q;
    assign gif.loser        = loser_q;
    assign gif.move_count   = count_q;
endmodule

// File: tb/tb_go_game_ctrl.sv
// Randomized self-checking bench for go_game_ctrl against a move-level game model.
module tb_go_game_ctrl;
    localparam int N   = 9;
    localparam int TO  = 15;
    localparam int CW  = 4;
    localparam int BW  = 2 * N * N;
    localparam int WIN = 20;
    localparam int V_OK = 0, V_INV = 1, V_BOTH = 2, V_NONE = 3;

    logic clk_in   = 1'b0;
    logic rst_in_n = 1'b0;

    go_game_ctrl_if #(.BOARD_N(N), .CNT_W(CW)) gif();

    go_game_ctrl #(.BOARD_N(N), .UPD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .gif      (gif)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Game model
    logic [BW-1:0] m_board, m_ko;
    logic          m_turn, m_over, m_res, m_loser;
    int            m_passes, m_count;
    logic [7:0]    m_upd_move;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < BW; i++) b[i] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic model_reset();
        m_board = '0; m_ko = '0; m_turn = 1'b0; m_over = 1'b0; m_res = 1'b0;
        m_loser = 1'b0; m_passes = 0; m_count = 0; m_upd_move = 8'h00;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_board"}, 256'(gif.board_bus), 256'(m_board));
        check_eq({tag, "_ko"},    256'(gif.ko_board), 256'(m_ko));
        check_eq({tag, "_flags"},
                 256'({gif.turn, gif.game_over, gif.resigned, gif.loser, gif.busy}),
                 256'({m_turn, m_over, m_res, m_res & m_loser, m_over}));
        check_eq({tag, "_count"}, 256'(gif.move_count), 256'(m_count));
        check_eq({tag, "_updmv"}, 256'(gif.upd_move), 256'(m_upd_move));
    endtask

    // Asserts reset for one cycle and checks outputs clear asynchronously
    task automatic apply_reset();
        @(negedge clk_in);
        rst_in_n = 1'b0;
        #1;
        model_reset();
        check_state("reset");
        check_eq("reset_pulses", 256'({gif.tx_ready, gif.invalid_move, gif.upd_start}), 256'(0));
        @(negedge clk_in);
        rst_in_n = 1'b1;
    endtask

    task automatic model_send(input logic mine, output int e_tx);
        e_tx     = (m_turn == mine) ? 1 : 0;
        m_turn   = ~m_turn;
        m_count  = (m_count >= (1 << CW) - 1) ? (1 << CW) - 1 : m_count + 1;
        if (m_passes == 2) m_over = 1'b1;
    endtask

    // Issues one move, emulates the updater, and checks pulses, latency and end state
    task automatic do_move(input string tag, input logic [7:0] mv, input int verdict, input int delay);
        logic [BW-1:0] nb, prev_board;
        logic mine;
        int n_tx = 0, n_inv = 0, n_st = 0, i_tx = -1, i_inv = -1, i_st = -1, i_brd = -1;
        int e_tx = 0, e_inv = 0, e_st = 0, e_tx_i = -1, e_inv_i = -1, e_st_i = -1, e_brd_i = -1;
        int v_idx;
        nb   = rand_board();
        mine = 1'($urandom_range(0, 1));
        v_idx = 1 + delay;
        gif.my_color       = mine;
        gif.upd_next_board = nb;

        if (!m_over) begin
            m_upd_move = mv;
            if (mv == 8'hFE) begin
                m_over = 1'b1; m_res = 1'b1; m_loser = m_turn;
            end else if (mv == 8'hFF) begin
                m_passes = (m_passes >= 2) ? 2 : m_passes + 1;
                m_ko = '0;
                model_send(mine, e_tx);
                e_tx_i = (e_tx == 1) ? 2 : -1;
            end else if (int'(mv[7:4]) >= N || int'(mv[3:0]) >= N) begin
                e_inv = 1; e_inv_i = 1;
            end else begin
                e_st = 1; e_st_i = 1;
                if (verdict == V_OK) begin
                    m_ko = m_board;
                    e_brd_i = (nb !== m_board) ? v_idx + 2 : -1;
                    m_board = nb;
                    m_passes = 0;
                    model_send(mine, e_tx);
                    e_tx_i = (e_tx == 1) ? v_idx + 3 : -1;
                end else begin
                    e_inv = 1;
                    e_inv_i = (verdict == V_NONE) ? TO + 2 : v_idx + 1;
                end
            end
        end

        prev_board     = gif.board_bus;
        gif.move_avail = 1'b1;
        gif.move       = mv;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk_in);
            gif.move_avail  = 1'b0;
            gif.upd_valid   = 1'b0;
            gif.upd_invalid = 1'b0;
            if (gif.tx_ready)     begin n_tx++;  if (i_tx  < 0) i_tx  = c; end
            if (gif.invalid_move) begin n_inv++; if (i_inv < 0) i_inv = c; end
            if (gif.upd_start)    begin n_st++;  if (i_st  < 0) i_st  = c; end
            if (i_brd < 0 && gif.board_bus !== prev_board) i_brd = c;
            if (e_st == 1 && c == v_idx) begin
                gif.upd_valid   = (verdict == V_OK || verdict == V_BOTH);
                gif.upd_invalid = (verdict == V_INV || verdict == V_BOTH);
            end
            // Stray strobes while busy must be dropped silently
            if (c < WIN - 2 && gif.busy && $urandom_range(0, 3) == 0) begin
                gif.move_avail = 1'b1;
                gif.move       = 8'($urandom);
            end
        end

        check_eq({tag, "_tx_n"},   256'(n_tx),  256'(e_tx));
        check_eq({tag, "_tx_at"},  256'(i_tx),  256'(e_tx_i));
        check_eq({tag, "_inv_n"},  256'(n_inv), 256'(e_inv));
        check_eq({tag, "_inv_at"}, 256'(i_inv), 256'(e_inv_i));
        check_eq({tag, "_st_n"},   256'(n_st),  256'(e_st));
        check_eq({tag, "_st_at"},  256'(i_st),  256'(e_st_i));
        check_eq({tag, "_brd_at"}, 256'(i_brd), 256'(e_brd_i));
        check_state(tag);
    endtask

    initial begin
        gif.move_avail = 1'b0; gif.move = 8'h00; gif.my_color = 1'b0;
        gif.upd_next_board = '0; gif.upd_valid = 1'b0; gif.upd_invalid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        rst_in_n = 1'b1;
        apply_reset();

        do_move("t1_place", 8'h44, V_OK, 2);
        do_move("t2_range", 8'h90, V_OK, 0);
        do_move("t2_col",   8'h09, V_OK, 0);
        do_move("t5_tmo",   8'h12, V_NONE, 0);
        do_move("t6_both",  8'h33, V_BOTH, 4);
        do_move("t6_inv",   8'h88, V_INV, 14);

        apply_reset();
        do_move("t3_pass1", 8'hFF, V_OK, 0);
        do_move("t3_pass2", 8'hFF, V_OK, 0);
        do_move("t3_late",  8'h44, V_OK, 1);

        apply_reset();
        do_move("t4_pass",  8'hFF, V_OK, 0);
        do_move("t4_place", 8'h00, V_OK, 0);
        do_move("t4_pass2", 8'hFF, V_OK, 0);
        do_move("t4_resgn", 8'hFE, V_OK, 0);

        // Reset while waiting for the updater
        apply_reset();
        @(negedge clk_in);
        gif.move_avail = 1'b1; gif.move = 8'h44;
        @(negedge clk_in);
        gif.move_avail = 1'b0;
        check_eq("t6_start", 256'({gif.upd_start, gif.busy}), 256'(2'b11));
        apply_reset();
        for (int c = 0; c < TO + 4; c++) begin
            @(negedge clk_in);
            check_eq("t6_quiet", 256'({gif.invalid_move, gif.tx_ready, gif.busy}), 256'(0));
        end

        for (int g = 0; g < 24; g++) begin
            apply_reset();
            for (int m = 0; m < 28; m++) begin
                int r, vr;
                logic [7:0] mv;
                r  = $urandom_range(0, 99);
                vr = $urandom_range(0, 99);
                if (r < 10)      mv = 8'hFF;
                else if (r < 12) mv = 8'hFE;
                else if (r < 17) mv = {4'($urandom_range(9, 14)), 4'($urandom_range(0, 15))};
                else if (r < 22) mv = {4'($urandom_range(0, 8)), 4'($urandom_range(9, 15))};
                else             mv = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
                do_move("rnd", mv,
                        (vr < 70) ? V_OK : (vr < 82) ? V_INV : (vr < 90) ? V_BOTH : V_NONE,
                        $urandom_range(0, 14));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
